// File: rtl/mem_pkg.sv
// Shared types and widths for the memory arbiter.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Merges the pipeline's fetch and load/store requesters onto a single
// picorv32-native memory bus, one outstanding transaction at a time.
// Data wins contention unless the fetch port has lost STARVE_LIMIT contended
// arbitrations in a row; a stuck bus is aborted after TIMEOUT wait cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_rsp_valid,
  output logic              i_rsp_err,
  output logic [WORD_W-1:0] i_rdata,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_rsp_valid,
  output logic              d_rsp_err,
  output logic [WORD_W-1:0] d_rdata,

  output logic              mem_valid,
  output logic              mem_instr,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int unsigned TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned SV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [SV_W-1:0] SV_MAX = SV_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [SV_W-1:0]   starve_q, starve_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_instr_q, mem_instr_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic              i_rsp_err_q, i_rsp_err_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic              d_rsp_err_q, d_rsp_err_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;

  logic idle;
  logic busy;
  logic i_win;
  logic d_win;
  logic timeout_hit;

  // The fetch port wins when alone or when it has been starved long enough.
  assign idle        = (state_q == IDLE);
  assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign i_win       = i_req_valid && (!d_req_valid || (starve_q == SV_MAX));
  assign d_win       = d_req_valid && !i_win;
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (to_cnt_q == TO_MAX);

  assign i_req_ready = idle && i_win;
  assign d_req_ready = idle && d_win;

  assign mem_valid   = mem_valid_q;
  assign mem_instr   = mem_instr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_err   = i_rsp_err_q;
  assign i_rdata     = i_rdata_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rdata     = d_rdata_q;

  // Arbiter next state: grant from IDLE, finish or abort from BUSY.
  always_comb begin
    state_d       = state_q;
    mem_valid_d   = mem_valid_q;
    mem_instr_d   = mem_instr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    i_rsp_valid_d = 1'b0;
    i_rsp_err_d   = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_err_d   = 1'b0;
    d_rdata_d     = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_win) begin
          state_d     = BUSY_I;
          mem_valid_d = 1'b1;
          mem_instr_d = 1'b1;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end else if (d_win) begin
          state_d     = BUSY_D;
          mem_valid_d = 1'b1;
          mem_instr_d = 1'b0;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
        end
      end
      BUSY_I: begin
        if (mem_ready || timeout_hit) begin
          state_d       = IDLE;
          mem_valid_d   = 1'b0;
          i_rsp_valid_d = 1'b1;
          i_rsp_err_d   = !mem_ready;
          i_rdata_d     = mem_ready ? mem_rdata : '0;
        end
      end
      BUSY_D: begin
        if (mem_ready || timeout_hit) begin
          state_d       = IDLE;
          mem_valid_d   = 1'b0;
          d_rsp_valid_d = 1'b1;
          d_rsp_err_d   = !mem_ready;
          d_rdata_d     = (mem_ready && (mem_wstrb_q == '0)) ? mem_rdata : '0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state, bus and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_valid_q   <= 1'b0;
      mem_instr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rdata_q     <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_instr_q   <= mem_instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rdata_q     <= i_rdata_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  // Timeout counter: restarts on every grant, counts wait cycles on the bus.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (idle && (i_win || d_win)) begin
      to_cnt_d = '0;
    end else if (busy && !mem_ready) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Starve counter: counts contended losses of the fetch port.
  always_comb begin
    starve_d = starve_q;
    if (idle) begin
      if (i_win) begin
        starve_d = '0;
      end else if (d_win && i_req_valid) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all checked against a transaction-level model of the arbiter rules.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam int SL = 4;

  logic        clk;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_addr;
  logic        i_rsp_valid;
  logic        i_rsp_err;
  logic [31:0] i_rdata;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rsp_valid;
  logic        d_rsp_err;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests and consecutive contended fetch losses.
  bit   pend_i;
  bit   pend_d;
  int   starve_m;
  logic obs_instr;

  mem_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present pending requests at a negedge in IDLE, serve the winner with
  // `waits` wait states (timeout if waits > TO) and check the response.
  task automatic apply_stimulus(input int waits, input logic [31:0] rd);
    bit          win_i;
    bit          e_err;
    bit          done;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    i_req_valid = pend_i;
    d_req_valid = pend_d;
    #1;
    win_i = pend_i && (!pend_d || starve_m == SL);
    if (win_i) starve_m = 0;
    else if (pend_i && pend_d) starve_m++;
    check_output("i_req_ready", 32'(i_req_ready), 32'(win_i));
    check_output("d_req_ready", 32'(d_req_ready), 32'(pend_d && !win_i));
    e_addr  = win_i ? i_addr : d_addr;
    e_wdata = win_i ? 32'h0 : d_wdata;
    e_wstrb = win_i ? 4'h0 : d_wstrb;
    e_err   = waits > TO;
    e_rdata = (e_err || (!win_i && d_wstrb != 4'h0)) ? 32'h0 : rd;
    @(negedge clk);
    if (win_i) begin
      pend_i = 0;
      i_req_valid = 1'b0;
    end else begin
      pend_d = 0;
      d_req_valid = 1'b0;
    end
    obs_instr = mem_instr;
    check_output("mem_wdata", mem_wdata, e_wdata);
    check_output("i_rsp_pulse", 32'(i_rsp_valid), 32'h0);
    check_output("d_rsp_pulse", 32'(d_rsp_valid), 32'h0);
    done = 0;
    for (int c = 0; !done; c++) begin
      check_output("mem_valid_busy", 32'(mem_valid), 32'h1);
      check_output("mem_instr", 32'(mem_instr), 32'(win_i));
      check_output("mem_addr", mem_addr, e_addr);
      check_output("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      check_output("ready_busy", 32'({i_req_ready, d_req_ready}), 32'h0);
      mem_ready = (c == waits);
      mem_rdata = (c == waits) ? rd : $urandom;
      done = (c == waits) || (c == TO);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check_output("mem_valid_done", 32'(mem_valid), 32'h0);
    check_output("i_rsp_valid", 32'(i_rsp_valid), 32'(win_i));
    check_output("d_rsp_valid", 32'(d_rsp_valid), 32'(!win_i));
    if (win_i) begin
      check_output("i_rsp_err", 32'(i_rsp_err), 32'(e_err));
      check_output("i_rdata", i_rdata, e_rdata);
    end else begin
      check_output("d_rsp_err", 32'(d_rsp_err), 32'(e_err));
      check_output("d_rdata", d_rdata, e_rdata);
    end
  endtask

  // Requesters must hold valid until accepted.
  logic prev_iv, prev_ir, prev_dv, prev_dr;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_iv <= 1'b0; prev_ir <= 1'b0; prev_dv <= 1'b0; prev_dr <= 1'b0;
    end else begin
      if (prev_iv && !prev_ir) assert (i_req_valid) else begin
        errors++;
        $error("[TB] FAIL i_valid_hold: observed 0 expected 1");
      end
      if (prev_dv && !prev_dr) assert (d_req_valid) else begin
        errors++;
        $error("[TB] FAIL d_valid_hold: observed 0 expected 1");
      end
      prev_iv <= i_req_valid; prev_ir <= i_req_ready;
      prev_dv <= d_req_valid; prev_dr <= d_req_ready;
    end
  end

  initial begin
    int r;
    int waits;
    reset = 1'b0;
    i_req_valid = 1'b0; i_addr = '0;
    d_req_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    pend_i = 0; pend_d = 0; starve_m = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_mem_valid", 32'(mem_valid), 32'h0);
    check_output("rst_mem_instr", 32'(mem_instr), 32'h0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check_output("rst_i_rsp", 32'({i_rsp_valid, i_rsp_err}), 32'h0);
    check_output("rst_i_rdata", i_rdata, 32'h0);
    check_output("rst_d_rsp", 32'({d_rsp_valid, d_rsp_err}), 32'h0);
    check_output("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_output("idle_mem_valid", 32'(mem_valid), 32'h0);
    check_output("idle_ready", 32'({i_req_ready, d_req_ready}), 32'h0);

    // Single zero-wait load
    $display("[TB] single load");
    pend_d = 1; d_addr = 32'h100; d_wdata = 32'h0; d_wstrb = 4'h0;
    apply_stimulus(0, 32'hDEADBEEF);

    // Store with three wait states
    $display("[TB] store");
    pend_d = 1; d_addr = 32'h200; d_wdata = 32'h1234ABCD; d_wstrb = 4'b0011;
    apply_stimulus(3, 32'h5A5A5A5A);

    // Continuous contention: D,D,D,D,I,D,D,D,D,I
    $display("[TB] contention");
    for (int k = 0; k < 10; k++) begin
      if (!pend_i) begin pend_i = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
      if (!pend_d) begin
        pend_d = 1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'h0;
      end
      apply_stimulus(0, $urandom);
      check_output("grant_seq", 32'(obs_instr), 32'((k == 4) || (k == 9)));
    end
    apply_stimulus(1, $urandom);

    // Fetch timeout
    $display("[TB] timeout");
    pend_i = 1; i_addr = 32'h40;
    apply_stimulus(1000, 32'hFFFFFFFF);

    // Ready arriving in the cycle the counter reaches TIMEOUT
    $display("[TB] late ready");
    pend_d = 1; d_addr = 32'h300; d_wdata = 32'h0; d_wstrb = 4'h0;
    apply_stimulus(TO, 32'hCAFEF00D);

    // Randomized traffic
    $display("[TB] random");
    repeat (40) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1; d_addr = $urandom; d_wdata = $urandom;
        d_wstrb = ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0;
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      r = $urandom_range(0, 9);
      waits = (r < 8) ? (r % 4) : ((r == 8) ? TO : TO + 3);
      apply_stimulus(waits, $urandom);
    end
    while (pend_i || pend_d) apply_stimulus(0, $urandom);

    // Reset in the middle of a data access
    $display("[TB] reset mid-transaction");
    d_addr = 32'h500; d_wdata = 32'h0; d_wstrb = 4'h0;
    d_req_valid = 1'b1;
    #1;
    check_output("mid_d_ready", 32'(d_req_ready), 32'h1);
    @(negedge clk);
    d_req_valid = 1'b0;
    check_output("mid_mem_valid", 32'(mem_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_mem_valid", 32'(mem_valid), 32'h0);
    check_output("async_d_rsp", 32'(d_rsp_valid), 32'h0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    starve_m = 0;
    repeat (2) begin
      @(negedge clk);
      check_output("post_rst_d_rsp", 32'(d_rsp_valid), 32'h0);
      check_output("post_rst_mem_valid", 32'(mem_valid), 32'h0);
    end
    pend_i = 1; i_addr = 32'h600;
    apply_stimulus(0, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
